// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit with an internal word memory, a programmable
//               wait latency and byte/halfword lane handling.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic [31:0] Wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [3:0] c_LAT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LH  = 6'h21;
    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SH  = 6'h29;
    localparam logic [5:0] c_OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic f_is_mem(input logic [5:0] op);
        return (op == c_OP_LB)  || (op == c_OP_LH)  || (op == c_OP_LW) ||
               (op == c_OP_LBU) || (op == c_OP_LHU) || (op == c_OP_SB) ||
               (op == c_OP_SH)  || (op == c_OP_SW);
    endfunction

    function automatic logic f_is_store(input logic [5:0] op);
        return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
    endfunction

    function automatic logic f_misaligned(input logic [5:0] op, input logic [1:0] a);
        if ((op == c_OP_LH) || (op == c_OP_LHU) || (op == c_OP_SH))
            return a[0];
        else if ((op == c_OP_LW) || (op == c_OP_SW))
            return (a != 2'b00);
        else
            return 1'b0;
    endfunction

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [5:0]  r_op;
    logic [31:0] r_result;
    logic [31:0] r_sdata;
    logic [31:0] r_mem [DEPTH];

    logic            w_in_mem;
    logic            w_in_mis;
    logic [c_AW-1:0] w_idx;
    logic [1:0]      w_off;
    logic [31:0]     w_rword;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load;
    logic [3:0]      w_mask;
    logic [31:0]     w_wdata;
    logic            w_we;
    logic            w_unused;

    // Only the opcode field of the instruction matters to this unit.
    assign w_unused  = ^Ins[25:0];

    assign w_in_mem  = f_is_mem(Ins[31:26]);
    assign w_in_mis  = f_misaligned(Ins[31:26], Result[1:0]);

    assign w_idx     = r_result[c_AW+1:2];
    assign w_off     = r_result[1:0];
    assign w_rword   = r_mem[w_idx];
    assign w_shifted = w_rword >> {w_off, 3'b000};
    assign w_we      = (r_state == S_ACCESS) && f_is_store(r_op);

    always_comb begin
        w_load = w_shifted;
        case (r_op)
            c_OP_LB:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_OP_LBU: w_load = {24'd0, w_shifted[7:0]};
            c_OP_LH:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_OP_LHU: w_load = {16'd0, w_shifted[15:0]};
            default:  w_load = w_shifted;
        endcase
    end

    // Store data is replicated across lanes so the mask alone picks the target.
    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = r_sdata;
        case (r_op)
            c_OP_SB: begin
                w_mask  = 4'b0001 << w_off;
                w_wdata = {4{r_sdata[7:0]}};
            end
            c_OP_SH: begin
                w_mask  = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_sdata[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = r_sdata;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_op     <= 6'd0;
            r_result <= 32'd0;
            r_sdata  <= 32'd0;
            Wdata    <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done     <= 1'b0;
                    misalign <= 1'b0;
                    if (start) begin
                        r_op     <= Ins[31:26];
                        r_result <= Result;
                        r_sdata  <= Rdata2;
                        if (!w_in_mem) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            Wdata   <= Result;
                        end else if (w_in_mis) begin
                            r_state  <= S_DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                            Wdata    <= 32'd0;
                        end else if (LAT > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_LAT_INIT;
                            busy    <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                            busy    <= 1'b1;
                        end
                    end else if (r_state == S_DONE) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_ACCESS;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_ACCESS: begin
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    Wdata   <= f_is_store(r_op) ? r_result : w_load;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit (LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] Ins;
    logic [31:0] Result;
    logic [31:0] Rdata2;
    logic [31:0] Wdata;
    logic        busy;
    logic        done;
    logic        misalign;

    int n_pass  = 0;
    int n_total = 0;

    int          edges;
    int          bcyc;
    int          dcount;
    logic [31:0] wd;
    logic        mis;

    mem_access_unit #(.DEPTH(1024), .LAT(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .Ins      (Ins),
        .Result   (Result),
        .Rdata2   (Rdata2),
        .Wdata    (Wdata),
        .busy     (busy),
        .done     (done),
        .misalign (misalign)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one request from a negedge. edges counts rising edges after the
    // edge that sampled start until done is seen; -1 means done never came.
    task automatic run_op(input logic [5:0] op, input logic [31:0] res, input logic [31:0] d,
                          output int e, output int bc, output logic [31:0] w, output logic m);
        start  = 1'b1;
        Ins    = {op, 26'($urandom)};
        Result = res;
        Rdata2 = d;
        e  = 0;
        bc = 0;
        @(posedge CLK);
        @(negedge CLK);
        start  = 1'b0;
        Ins    = {OP_SW, 26'($urandom)};
        Result = $urandom;
        Rdata2 = $urandom;
        while (!done && e < 40) begin
            bc += int'(busy);
            @(posedge CLK);
            @(negedge CLK);
            e++;
        end
        w = Wdata;
        m = misalign;
        if (!done) e = -1;
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_wdata", Wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        RST = 1'b1;

        // First start right after reset release; store then load back.
        run_op(OP_SW, 32'h10, 32'hDEADBEEF, edges, bcyc, wd, mis);
        check("sw10_latency", 32'(edges), 32'd3);
        check("sw10_busy_cycles", 32'(bcyc), 32'd3);
        check("sw10_wdata", wd, 32'h10);
        run_op(OP_LW, 32'h10, 32'h0, edges, bcyc, wd, mis);
        check("lw10_latency", 32'(edges), 32'd3);
        check("lw10_busy_cycles", 32'(bcyc), 32'd3);
        check("lw10_wdata", wd, 32'hDEADBEEF);
        check("lw10_misalign", 32'(mis), 32'd0);

        run_op(OP_SB, 32'h13, 32'h000000A5, edges, bcyc, wd, mis);
        check("sb13_wdata", wd, 32'h13);
        run_op(OP_LB, 32'h13, 32'h0, edges, bcyc, wd, mis);
        check("lb13", wd, 32'hFFFFFFA5);
        run_op(OP_LBU, 32'h13, 32'h0, edges, bcyc, wd, mis);
        check("lbu13", wd, 32'h000000A5);
        run_op(OP_LW, 32'h10, 32'h0, edges, bcyc, wd, mis);
        check("lw10_after_sb", wd, 32'hA5ADBEEF);

        run_op(OP_LH, 32'h12, 32'h0, edges, bcyc, wd, mis);
        check("lh12", wd, 32'hFFFFA5AD);
        run_op(OP_LHU, 32'h12, 32'h0, edges, bcyc, wd, mis);
        check("lhu12", wd, 32'h0000A5AD);
        run_op(OP_LH, 32'h11, 32'h0, edges, bcyc, wd, mis);
        check("lh11_latency", 32'(edges), 32'd0);
        check("lh11_misalign", 32'(mis), 32'd1);
        check("lh11_wdata", wd, 32'd0);
        run_op(OP_SW, 32'h12, 32'h11111111, edges, bcyc, wd, mis);
        check("sw12_latency", 32'(edges), 32'd0);
        check("sw12_misalign", 32'(mis), 32'd1);
        check("sw12_wdata", wd, 32'd0);
        run_op(OP_LW, 32'h10, 32'h0, edges, bcyc, wd, mis);
        check("lw10_unchanged", wd, 32'hA5ADBEEF);

        // Address wraps modulo 4*DEPTH bytes.
        run_op(OP_SW, 32'h1000, 32'h12345678, edges, bcyc, wd, mis);
        run_op(OP_LW, 32'h0, 32'h0, edges, bcyc, wd, mis);
        check("lw0_wrap", wd, 32'h12345678);
        run_op(OP_SH, 32'h2, 32'hFFFF9876, edges, bcyc, wd, mis);
        run_op(OP_LW, 32'h0, 32'h0, edges, bcyc, wd, mis);
        check("lw0_after_sh", wd, 32'h98765678);

        // Reset in WAIT aborts the store.
        run_op(OP_SW, 32'h20, 32'hCAFEF00D, edges, bcyc, wd, mis);
        start = 1'b1; Ins = {OP_SW, 26'd0}; Result = 32'h20; Rdata2 = 32'h1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        RST = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wdata", Wdata, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        dcount = 0;
        repeat (8) begin
            @(posedge CLK);
            @(negedge CLK);
            dcount += int'(done);
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        run_op(OP_LW, 32'h20, 32'h0, edges, bcyc, wd, mis);
        check("abort_lw_latency", 32'(edges), 32'd3);
        check("abort_lw_wdata", wd, 32'hCAFEF00D);

        run_op(OP_R, 32'h1234, 32'h0, edges, bcyc, wd, mis);
        check("rtype_latency", 32'(edges), 32'd0);
        check("rtype_wdata", wd, 32'h1234);
        check("rtype_misalign", 32'(mis), 32'd0);

        // A start pulse while busy must be dropped, not queued.
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b1; Ins = {OP_LW, 26'd0}; Result = 32'h0; Rdata2 = 32'h0;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b1; Ins = {OP_SW, 26'd0}; Result = 32'h0; Rdata2 = 32'h0;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        dcount = 0;
        wd = 32'd0;
        repeat (10) begin
            if (done) begin
                dcount++;
                wd = Wdata;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        check("ignore_done_count", 32'(dcount), 32'd1);
        check("ignore_lw_wdata", wd, 32'h98765678);
        run_op(OP_LW, 32'h0, 32'h0, edges, bcyc, wd, mis);
        check("ignore_mem_intact", wd, 32'h98765678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 1024: data memory size in 32-bit words, power of two, minimum 4.
REQ-002 Parameter LAT, default 2: wait cycles before each memory access, range 0..15.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request valid; sampled only in IDLE or DONE.
REQ-006 Ins  input  32  instruction; Ins[31:26] selects the operation.
REQ-007 Result  input  32  byte address for memory ops; pass-through value otherwise.
REQ-008 Rdata2  input  32  store data.
REQ-009 Wdata  output  32  write-back data; registered; held until the next done.
REQ-010 busy  output  1  high in WAIT and ACCESS.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 misalign  output  1  high together with done when the completed request was misaligned.

Function
REQ-013 Opcodes shall be LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; all other opcodes are non-memory ops.
REQ-014 Memory shall be little-endian: byte offset n (address[1:0]) maps to word bits [8n+7:8n].
REQ-015 Word index shall be address[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-016 The FSM shall have states IDLE, WAIT, ACCESS and DONE.
REQ-017 From IDLE or DONE with start=1 and an aligned memory op: go to WAIT with the wait counter loaded to LAT-1 if LAT>0, else go directly to ACCESS.
REQ-018 In WAIT: decrement the counter, and go to ACCESS on the edge where the counter is 0.
REQ-019 On the edge leaving ACCESS: perform the read or the byte-lane write, update Wdata, and go to DONE.
REQ-020 done shall therefore rise LAT+1 edges after the edge that sampled start.
REQ-021 From IDLE or DONE with start=1 and a non-memory op: go to DONE next edge with Wdata=Result and no memory access.
REQ-022 Misaligned requests are LH/LHU/SH with address[0]=1, and LW/SW with address[1:0]!=0.
REQ-023 From IDLE or DONE with start=1 and a misaligned request: go to DONE next edge with misalign=1, Wdata=0, and no memory write.
REQ-024 DONE shall go to IDLE when start=0.
REQ-025 In DONE, a new start shall be accepted immediately (back-to-back operation), with done low in the following cycle.
REQ-026 start in WAIT or ACCESS shall be ignored, with no queuing.
REQ-027 Ins, Result and Rdata2 shall be captured at acceptance; later input changes shall not affect the in-flight request.
REQ-028 Loads: LB/LH sign-extend and LBU/LHU zero-extend the selected byte or halfword; LW returns the full word.
REQ-029 Stores: SB writes only the addressed byte lane with Rdata2[7:0]; SH writes only the addressed halfword with Rdata2[15:0]; SW writes all lanes.
REQ-030 For stores, Wdata shall be set to Result at completion.
REQ-031 Memory contents shall be undefined at power-up and shall not be cleared by reset.

Reset
REQ-032 While RST=0: state is IDLE, the counter is 0, and Wdata=0, busy=0, done=0, misalign=0.
REQ-033 Reset asserted during WAIT or ACCESS shall abort the request: no memory write occurs and no done pulse follows.
REQ-034 After RST deasserts, the first start shall be sampled on the first rising edge.

Verification (DEPTH=1024, LAT=2)
REQ-035 SW, Result=0x10, Rdata2=0xDEADBEEF, then LW at 0x10 -> each done rises 3 edges after start; busy high for 3 cycles; LW Wdata=0xDEADBEEF.
REQ-036 SB at 0x13 with Rdata2=0x000000A5 -> LB 0x13 gives 0xFFFFFFA5; LBU 0x13 gives 0x000000A5; LW 0x10 gives 0xA5ADBEEF.
REQ-037 LH 0x12 gives 0xFFFFA5AD; LHU 0x12 gives 0x0000A5AD; LH 0x11 gives done+misalign after 1 edge with Wdata=0; SW 0x12 gives misalign with memory unchanged.
REQ-038 SW at 0x1000 with Rdata2=0x12345678, then LW 0x0 -> Wdata=0x12345678 (wrap-around).
REQ-039 SW at 0x20 with Rdata2=0x1; RST low for 1 cycle during WAIT; then LW 0x20 -> prior value returned; no done pulse for the aborted SW.
REQ-040 R-type request (Ins[31:26]=0, Result=0x1234) -> done after 1 edge with Wdata=0x1234; a second start pulse during a busy LW is ignored, giving exactly one done.
